// File: rtl/axi4_lite_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_write_arbiter_if
// Bundles every bus signal of the write arbiter: the local requester side
// (flat per-requester request/response vectors), the start/done handshake
// with the AW and W channel blocks, and the AXI B channel.
//
// Handshake semantics (one place, applies to the whole bundle):
//   - A requester raises req_valid[i] together with its addr/data/strb slice
//     and holds all of them stable until it sees req_ready[i]=1 for one
//     cycle. If req_valid[i] is still high in the cycle after that pulse it
//     is taken as a brand-new request.
//   - rsp_valid[i] is a one-cycle pulse to the owner; rsp_resp is only
//     meaningful in that cycle.
//   - STARTWA/STARTWD are one-cycle starts; the channel blocks answer with
//     one-cycle aw_DONE/wd_DONE pulses and report aw_IDLE/wd_IDLE when free.
//   - B channel: a response transfers in a cycle where BVALID && BREADY.
//
// Modports:
//   slave  - the arbiter side (drives grants, starts, BREADY, responses)
//   master - the environment side (requesters, channel blocks, B channel)
// ---------------------------------------------------------------------------
interface axi4_lite_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // requester side
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [1:0]                    rsp_resp;
  logic                          busy;

  // AW channel block
  logic                          STARTWA;
  logic [ADDR_WIDTH-1:0]         wa_addr;
  logic                          aw_IDLE;
  logic                          aw_DONE;

  // W channel block
  logic                          STARTWD;
  logic [DATA_WIDTH-1:0]         wd_data;
  logic [STRB_WIDTH-1:0]         wd_strb;
  logic                          wd_IDLE;
  logic                          wd_DONE;

  // B channel
  logic                          BVALID;
  logic [1:0]                    BRESP;
  logic                          BREADY;

  modport slave (
    input  req_valid, req_addr, req_data, req_strb,
    input  aw_IDLE, aw_DONE, wd_IDLE, wd_DONE, BVALID, BRESP,
    output req_ready, rsp_valid, rsp_resp, busy,
    output STARTWA, wa_addr, STARTWD, wd_data, wd_strb, BREADY
  );

  modport master (
    output req_valid, req_addr, req_data, req_strb,
    output aw_IDLE, aw_DONE, wd_IDLE, wd_DONE, BVALID, BRESP,
    input  req_ready, rsp_valid, rsp_resp, busy,
    input  STARTWA, wa_addr, STARTWD, wd_data, wd_strb, BREADY
  );
endinterface

// File: rtl/axi4_lite_write_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_lite_write_arbiter
// Shares one AXI4-Lite write path among NUM_REQ requesters with round-robin
// arbitration. Each granted write is sequenced end to end: start the AW and
// W channel blocks, wait for both DONE pulses (any order), collect the B
// response, and return it to the requester that owns the transaction.
//
// Ports:
//   ACLK       clock
//   ARESET     synchronous, active-high reset
//   bus        axi4_lite_write_arbiter_if.slave (requesters, AW/W blocks, B)
//   dbg_state  current FSM state: 0=IDLE, 1=WAIT_AW_W, 2=WAIT_B
// ---------------------------------------------------------------------------
module axi4_lite_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  axi4_lite_write_arbiter_if.slave      bus,
  output logic [1:0]                    dbg_state
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_AW_W = 2'd1,
    ST_WAIT_B    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] wa_addr_q, wa_addr_d;
  logic [DATA_WIDTH-1:0] wd_data_q, wd_data_d;
  logic [STRB_WIDTH-1:0] wd_strb_q, wd_strb_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  start_wa_q, start_wa_d;
  logic                  start_wd_q, start_wd_d;
  logic                  aw_seen_q, aw_seen_d;
  logic                  w_seen_q, w_seen_d;

  // Round-robin search: first active requester after last_grant, wrapping.
  logic                  found;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      cand;
  int                    arb_idx;

  always_comb begin
    found   = 1'b0;
    winner  = '0;
    cand    = '0;
    arb_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_idx = (int'(last_grant_q) + k) % NUM_REQ;
      cand    = IDX_W'(arb_idx);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Payload slices of the current winner.
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [STRB_WIDTH-1:0] sel_strb;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_strb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == winner) begin
        sel_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb = bus.req_strb[i*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  // Next-state and registered-output logic. Pulse outputs default to 0 so
  // every grant/start/response lasts exactly one cycle.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wa_addr_d    = wa_addr_q;
    wd_data_d    = wd_data_q;
    wd_strb_d    = wd_strb_q;
    aw_seen_d    = aw_seen_q;
    w_seen_d     = w_seen_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_resp_d   = 2'b00;
    start_wa_d   = 1'b0;
    start_wd_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Both channel blocks must be free before a new write is launched.
        if (found && bus.aw_IDLE && bus.wd_IDLE) begin
          owner_d      = winner;
          last_grant_d = winner;
          wa_addr_d    = sel_addr;
          wd_data_d    = sel_data;
          wd_strb_d    = sel_strb;
          req_ready_d  = NUM_REQ'(1) << winner;
          start_wa_d   = 1'b1;
          start_wd_d   = 1'b1;
          aw_seen_d    = 1'b0;
          w_seen_d     = 1'b0;
          state_d      = ST_WAIT_AW_W;
        end
      end

      ST_WAIT_AW_W: begin
        // A DONE arriving this cycle counts immediately, so simultaneous or
        // staggered completions both exit on the cycle the second one lands.
        aw_seen_d = aw_seen_q | bus.aw_DONE;
        w_seen_d  = w_seen_q  | bus.wd_DONE;
        if (aw_seen_d && w_seen_d) begin
          state_d = ST_WAIT_B;
        end
      end

      ST_WAIT_B: begin
        if (bus.BVALID) begin
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_resp_d  = bus.BRESP;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      wa_addr_q    <= '0;
      wd_data_q    <= '0;
      wd_strb_q    <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_resp_q   <= 2'b00;
      start_wa_q   <= 1'b0;
      start_wd_q   <= 1'b0;
      aw_seen_q    <= 1'b0;
      w_seen_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wa_addr_q    <= wa_addr_d;
      wd_data_q    <= wd_data_d;
      wd_strb_q    <= wd_strb_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_resp_q   <= rsp_resp_d;
      start_wa_q   <= start_wa_d;
      start_wd_q   <= start_wd_d;
      aw_seen_q    <= aw_seen_d;
      w_seen_q     <= w_seen_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.STARTWA   = start_wa_q;
  assign bus.wa_addr   = wa_addr_q;
  assign bus.STARTWD   = start_wd_q;
  assign bus.wd_data   = wd_data_q;
  assign bus.wd_strb   = wd_strb_q;
  // Decoded from the state register so it stays glitch-free for all of WAIT_B.
  assign bus.BREADY    = (state_q == ST_WAIT_B);
  assign dbg_state     = state_q;

endmodule
